// File: rtl/sysfn_pkg.sv
// Shared types for the sampled-value history tracker and the system-function checker stage.
package sysfn_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FIRST   = 2'd1,
        FILLING = 2'd2,
        READY   = 2'd3
    } hist_state_e;

    typedef struct packed {
        logic rose;
        logic fell;
        logic changed;
        logic stable;
    } sample_flags_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sampled_history.sv
// Registers din on sample_en and exposes $past/$rose/$fell/$stable/$changed equivalents as registers.
//   state   | meaning
//   EMPTY   | nothing sampled since reset
//   FIRST   | cur_q valid, no history yet
//   FILLING | history partially valid, fill < DEPTH
//   READY   | history full, stays here until rst
module sampled_history
    import sysfn_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_en,
    input  logic [W-1:0]               din,
    input  logic [$clog2(DEPTH)-1:0]   past_sel,
    output logic [W-1:0]               cur_q,
    output logic [W-1:0]               past_q,
    output logic                       rose,
    output logic                       fell,
    output logic                       changed,
    output logic                       stable,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       ready,
    output logic [CW-1:0]              change_count
);

    localparam int FW = $clog2(DEPTH + 1);

    hist_state_e   state_q, state_d;
    logic [FW-1:0] fill_q, fill_d;
    sample_flags_t flags_q, flags_d;
    logic [W-1:0]  hist_q [DEPTH];
    logic [W-1:0]  prev;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        flags_d = flags_q;
        // Until something has been sampled, the past value reads as zero like $past.
        prev    = (state_q == EMPTY) ? '0 : cur_q;
        if (sample_en) begin
            flags_d.changed = (din !== prev);
            flags_d.rose    = (din[0] === 1'b1) && (prev[0] === 1'b0);
            flags_d.fell    = (din[0] === 1'b0) && (prev[0] === 1'b1);
            flags_d.stable  = (state_q != EMPTY) && !flags_d.changed;
            case (state_q)
                EMPTY: state_d = FIRST;
                FIRST: begin
                    fill_d  = FW'(1);
                    state_d = FILLING;
                end
                FILLING: begin
                    fill_d = fill_q + FW'(1);
                    if (fill_d == FW'(DEPTH)) begin
                        state_d = READY;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            fill_q  <= '0;
            flags_q <= '0;
            cur_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            flags_q <= flags_d;
            if (sample_en) begin
                cur_q     <= din;
                hist_q[0] <= cur_q;
                for (int i = 1; i < DEPTH; i++) begin
                    hist_q[i] <= hist_q[i-1];
                end
            end
        end
    end

    // Entries at or beyond fill are not yet valid and read as zero.
    always_comb begin
        past_q = '0;
        if (FW'(past_sel) < fill_q) begin
            past_q = hist_q[past_sel];
        end
    end

    sat_counter #(.CW(CW)) u_change_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sample_en && flags_d.changed),
        .count (change_count)
    );

    assign rose    = flags_q.rose;
    assign fell    = flags_q.fell;
    assign changed = flags_q.changed;
    assign stable  = flags_q.stable;
    assign fill    = fill_q;
    assign ready   = (fill_q == FW'(DEPTH));

endmodule

// File: doc/sampled_history.md
# sampled_history

Sampled-value history tracker that registers an input word on qualified clock edges and exposes `$past`/`$rose`/`$fell`/`$stable`/`$changed`-equivalent results as plain registered signals. It sits directly upstream of the system-function checker stage: the checker consumes these outputs instead of relying on simulator-evaluated sampled-value functions. This lets the same checks run in synthesis and in tools without assertion-function support.

## Interface
- `W`, default 8: sampled word width, ≥1.
- `DEPTH`, default 4: history depth (number of past samples kept), ≥2.
- `CW`, default 16: change-counter width.
- `clk` in, 1: single clock; all state updates on posedge.
- `rst` in, 1: synchronous, active-high reset.
- `sample_en` in, 1: take a sample of `din` this cycle.
- `din` in, W: value to sample.
- `past_sel` in, $clog2(DEPTH): history index; 0 = the sample before current, DEPTH-1 = oldest.
- `cur_q` out, W: most recent sample.
- `past_q` out, W: `hist[past_sel]`, combinational mux off registered history.
- `rose` out, 1: LSB of current sample is 1 and LSB of previous sample is 0.
- `fell` out, 1: LSB of current sample is 0 and LSB of previous sample is 1.
- `changed` out, 1: current sample ≠ previous sample (full word, 4-state `!==`).
- `stable` out, 1: `!changed` when `hist_valid[0]`, else 0.
- `fill` out, $clog2(DEPTH+1): number of valid history entries.
- `ready` out, 1: history full (`fill == DEPTH`).
- `change_count` out, CW: saturating count of samples with `changed`.

## Operation
- State machine with states EMPTY → FIRST → FILLING → READY.
  - EMPTY: no sample taken. `sample_en` → FIRST.
  - FIRST: `cur_q` valid, no history yet. `sample_en` → FILLING, or directly → READY if DEPTH==1 (excluded by parameter rule).
  - FILLING: `sample_en` increments `fill`; → READY when `fill` reaches DEPTH.
  - READY: terminal until `rst`.
- On each `sample_en`:
  - `hist[i] <= hist[i-1]` for i≥1.
  - `hist[0] <= cur_q`.
  - `cur_q <= din`.
  - Oldest entry is discarded.
- The past value compared by `rose`/`fell`/`changed` is `hist[0]`.
- Before `hist[0]` is valid (EMPTY/FIRST), the past value compares as `'0`, matching `$past` default semantics:
  - The first sample with LSB=1 asserts `rose`.
  - A nonzero first sample asserts `changed`.
- Flag outputs are registered and reflect the latest sample. They hold their value while `sample_en` is low; no decay.
- `change_count` increments on every sample whose `changed` is true and saturates at 2^CW−1.
- `past_sel` ≥ `fill` returns `'0`, never stale data.

## Timing
- Latency: sample at edge N appears on `cur_q` and the flags after edge N; visible in cycle N+1.
- `past_q` follows `past_sel` in the same cycle (combinational).
- Reset values: `cur_q`, all `hist` = 0; `rose`, `fell`, `changed`, `stable` = 0; `fill` = 0; `ready` = 0; `change_count` = 0; state EMPTY.
- `rst` and `sample_en` in the same cycle: reset wins and the sample is dropped.
- Reset mid-fill discards all history; the next sample is treated as the first.
- `sample_en` every cycle is supported at full rate, with no back-pressure.
- X/Z on `din` is stored unchanged.
  - `changed` is computed with `!==`, so X↔0 counts as a change.
  - `rose`/`fell` require a known 0/1 on both LSBs; X yields 0.

## Structure
- Package `sysfn_pkg`:
  - `hist_state_e` enum (EMPTY, FIRST, FILLING, READY).
  - `sample_flags_t` packed struct {rose, fell, changed, stable}, shared with the checker stage.
- Sub-module `sat_counter` (params `CW`; ports `clk`, `rst`, `inc`, `count`) provides `change_count` and is reused by the checker's error tallies.
- History shift register and flag logic stay in `sampled_history`.

## Test plan
- After `rst`: sample 1, 0, 1, 1 on consecutive cycles (W=8):
  - `rose` = 1, 0, 1, 0.
  - `fell` = 0, 1, 0, 0.
  - `stable` = 0, 0, 0, 1.
  - `change_count` = 3.
- DEPTH=4: sample 10, 20, 30, 40, 50; then `past_sel` = 0..3 → `past_q` = 40, 30, 20, 10.
  - `fill` reaches 4 and `ready` = 1 on the 5th sample's following cycle.
- Fill check: after 2 samples, `past_sel` = 2 → `past_q` = 0 and `fill` = 1.
- Saturation: CW=2, alternate 0/1 for 6 samples → `change_count` holds at 3.
- `sample_en` low for 10 cycles → all outputs hold.
  - `rst` asserted together with `sample_en` (din=0xFF) → all outputs 0, `fill` = 0.
- X handling: sample 0 then 8'hxx → `changed` = 1, `rose` = 0, `fell` = 0.
